// File: rtl/covid_sample_logger.sv
// Byte-stream capture engine: packs 8-bit Avalon-ST samples little-endian into
// 32-bit words and writes them to an Avalon-MM memory at an auto-incrementing address.
module covid_sample_logger #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10,
    parameter int WRAP   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              flush,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    output logic [31:0]       mem_writedata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic [ADDR_W:0]   word_count,
    output logic              wrapped
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   LAST_COUNT = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);

    logic [1:0]        state;
    logic [1:0]        state_nx;
    logic [1:0]        byte_idx;
    logic [3:0]        lane_mask;
    logic [3:0]        mask_nx;
    logic [23:0]       asm_q;
    logic [31:0]       asm_nx;
    logic [31:0]       flush_data;
    logic              accept;
    logic              complete;
    logic              start_ok;
    logic              flush_run;
    logic              flush_partial;
    logic              last_word;
    logic [ADDR_W-1:0] next_ptr;
    logic [ADDR_W:0]   issued_words;

    // Handshake: a byte transfers on any clock where in_valid and in_ready are both high;
    // in_ready is registered and never depends on in_valid.
    always_comb begin
        accept  = in_valid & in_ready;
        asm_nx  = {8'h00, asm_q};
        mask_nx = lane_mask;
        if (accept) begin
            asm_nx[8*byte_idx +: 8] = in_data;
            mask_nx[byte_idx]       = 1'b1;
        end
        complete      = accept & (byte_idx == 2'd3);
        start_ok      = start & ((state == IDLE) | (state == DONE));
        flush_run     = flush & (state == RUN);
        flush_partial = flush_run & ~complete & (mask_nx != 4'd0);

        flush_data = '0;
        for (int i = 0; i < 4; i++) begin
            flush_data[8*i +: 8] = mask_nx[i] ? asm_nx[8*i +: 8] : 8'h00;
        end

        // A write on the bus this cycle has not yet advanced wr_ptr/word_count.
        next_ptr = wr_ptr;
        if (mem_write) begin
            next_ptr = (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + 1'b1;
        end
        issued_words = word_count + {{ADDR_W{1'b0}}, mem_write};
        last_word    = (WRAP == 0) && (issued_words == LAST_COUNT);

        state_nx = state;
        case (state)
            IDLE, DONE: if (start) state_nx = RUN;
            RUN: begin
                if (flush) begin
                    state_nx = flush_partial ? FLUSH : DONE;
                end else if (complete && last_word) begin
                    state_nx = DONE;
                end
            end
            FLUSH:   state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            in_ready       <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            mem_write      <= 1'b0;
            mem_chipselect <= 1'b0;
            mem_address    <= '0;
            mem_byteenable <= 4'h0;
            mem_writedata  <= 32'h0;
            wr_ptr         <= '0;
            word_count     <= '0;
            wrapped        <= 1'b0;
            byte_idx       <= 2'd0;
            lane_mask      <= 4'h0;
            asm_q          <= 24'h0;
        end else begin
            state     <= state_nx;
            in_ready  <= (state_nx == RUN);
            busy      <= (state_nx == RUN) || (state_nx == FLUSH);
            done      <= (state_nx == DONE);
            mem_write      <= 1'b0;
            mem_chipselect <= 1'b0;

            if (complete) begin
                mem_write      <= 1'b1;
                mem_chipselect <= 1'b1;
                mem_address    <= next_ptr;
                mem_byteenable <= 4'hF;
                mem_writedata  <= {in_data, asm_q};
            end else if (flush_partial) begin
                mem_write      <= 1'b1;
                mem_chipselect <= 1'b1;
                mem_address    <= next_ptr;
                mem_byteenable <= mask_nx;
                mem_writedata  <= flush_data;
            end

            if (start_ok) begin
                wr_ptr     <= '0;
                word_count <= '0;
                wrapped    <= 1'b0;
                byte_idx   <= 2'd0;
                lane_mask  <= 4'h0;
                asm_q      <= 24'h0;
            end else begin
                wr_ptr <= next_ptr;
                if (mem_write) begin
                    if (word_count != FULL_COUNT) begin
                        word_count <= word_count + 1'b1;
                    end
                    if ((WRAP != 0) && (mem_address == '0) && (word_count == FULL_COUNT)) begin
                        wrapped <= 1'b1;
                    end
                end
                if (complete || flush_run) begin
                    byte_idx  <= 2'd0;
                    lane_mask <= 4'h0;
                end else if (accept) begin
                    asm_q     <= asm_nx[23:0];
                    byte_idx  <= byte_idx + 2'd1;
                    lane_mask <= mask_nx;
                end
            end
        end
    end

endmodule
